uart_axis_responder: RTL and testbench
======================================

Name: uart_axis_responder

Overview:
Command/response sequencer between the UART receiver and transmitter on the DE0-Nano accelerometer link. It decodes single-byte axis commands ('x', 'y', 'z') from the receiver and drives `dimension` to the accelerometer SPI reader. After a settle delay it captures the 16-bit sample and streams a framed response, byte by byte, into the transmitter using a start/busy handshake. It replaces ad-hoc combinational sequencing with one clocked FSM in the CLK_50 domain.

Parameters:
SETTLE_CYCLES, 50000, clocks to wait after setting dimension before capturing sample (1 ms at 50 MHz); legal range 1..2^20-1.
SEND_CHECKSUM, 1, 1 = append XOR checksum byte to each frame; 0 = 3-byte frame.

Ports:
CLK_50  in  1  system clock, 50 MHz
iRSTN  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_ready=1
rx_ready  in  1  one-cycle pulse, byte available
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle pulse, launch tx_data
tx_data  out  8  byte to transmit, held stable from tx_start until next load
sample  in  16  accelerometer sample for current dimension
dimension  out  3  axis select to SPI reader: 0=x, 1=y, 2=z
busy  out  1  high whenever FSM is not IDLE
cmd_dropped  out  1  one-cycle pulse, command ignored because busy
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async assert, sync release on CLK_50):
  - tx_start=0, tx_data=0x00, dimension=0, busy=0, cmd_dropped=0, frame_count=0.
  - FSM=IDLE; captured sample, header and checksum registers cleared.
- States: IDLE, SETTLE, LOAD, GUARD, DRAIN, DONE.
- IDLE, on rx_ready=1:
  - 0x78/0x79/0x7A: dimension <= 0/1/2 next cycle, header <= rx_data, settle counter cleared, go SETTLE.
  - Any other byte: dimension unchanged, one-byte frame {0x3F}, go LOAD directly; frame_count not incremented.
- SETTLE:
  - Counter increments each cycle.
  - On the cycle the counter reaches SETTLE_CYCLES-1, register sample into cap[15:0] and go LOAD.
  - Sample changes after capture never affect the frame.
- Frame order: header, cap[7:0], cap[15:8], then chk = header^cap[7:0]^cap[15:8] if SEND_CHECKSUM=1.
- Byte index register selects the current byte.
- LOAD:
  - Wait until tx_busy=0.
  - On that cycle assert tx_start=1 for exactly one cycle with tx_data = current byte, then go GUARD.
  - tx_start is never asserted while tx_busy=1.
- GUARD: one cycle with tx_busy ignored (covers the transmitter's one-cycle registered busy latency), then go DRAIN.
- DRAIN:
  - Wait for tx_busy=0.
  - If more bytes remain: index+1, go LOAD.
  - Otherwise go DONE.
- DONE:
  - frame_count+1 (axis frames only).
  - Go IDLE next cycle; busy falls on entry to IDLE.
- Busy handling: rx_ready=1 in any non-IDLE state gives cmd_dropped=1 the same cycle (registered output, visible next cycle). The byte is discarded and the FSM is unaffected.
- rx_ready in the same cycle DONE->IDLE: dropped. Only rx_ready sampled while in IDLE is accepted.
- Latency, axis command:
  - rx_ready to first tx_start = SETTLE_CYCLES + 2 clocks when tx_busy=0.
  - Back-to-back bytes are gated only by tx_busy.
- Reset mid-frame: all outputs return to reset values immediately. A transmission in flight is not aborted by this block.

Test Plan:
- SETTLE_CYCLES=4, SEND_CHECKSUM=1, sample=0xA55A, rx 0x78 -> dimension=0; tx bytes 0x78,0x5A,0xA5,0x87, each tx_start only while tx_busy=0; frame_count 0->1; busy low after last drain.
- rx 0x79 then 0x7A, sample=0x1234 -> dimension 1 then 2; second frame 0x7A,0x34,0x12,0x5C; frame_count=2.
- rx 0x71 -> single tx byte 0x3F; dimension unchanged; frame_count unchanged; busy returns low.
- During a frame, pulse rx_ready with 0x78 and change sample to 0xFFFF after capture -> cmd_dropped pulses once; frame bytes unchanged; no second frame.
- Hold tx_busy=1 for 100 cycles in LOAD -> tx_start stays 0; asserts exactly one cycle after tx_busy falls.
- Assert iRSTN=0 during DRAIN of byte 2 -> tx_start=0, busy=0, dimension=0, frame_count=0 immediately; after release, rx 0x7A produces a complete fresh frame.

Source files
------------

// File: rtl/uart_axis_responder.sv
// Command/response sequencer: decodes 'x'/'y'/'z' from the UART receiver, selects the
// accelerometer axis, waits for the reading to settle and streams a framed reply to the transmitter.
module uart_axis_responder #(
  parameter int SETTLE_CYCLES = 50000,
  parameter bit SEND_CHECKSUM = 1'b1
) (
  input  logic        CLK_50,
  input  logic        iRSTN,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic [15:0] sample,
  output logic [2:0]  dimension,
  output logic        busy,
  output logic        cmd_dropped,
  output logic [7:0]  frame_count
);

  // state  | meaning
  // IDLE   | waiting for a command byte
  // SETTLE | dimension driven, waiting for the SPI reader to settle
  // LOAD   | waiting for an idle transmitter, then launching the current byte
  // GUARD  | one cycle covering the transmitter's registered busy latency
  // DRAIN  | waiting for the transmitter to finish the current byte
  // DONE   | frame complete, bump the frame counter
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] GUARD  = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  localparam logic [1:0]  AXIS_LAST   = SEND_CHECKSUM ? 2'd3 : 2'd2;

  logic [2:0]  state;
  logic [19:0] settleCnt;
  logic [7:0]  header;
  logic [15:0] cap;
  logic [7:0]  chk;
  logic [1:0]  byteIdx;
  logic [1:0]  lastIdx;
  logic        axisFrame;
  logic        isAxisCmd;
  logic [7:0]  curByte;

  assign isAxisCmd = (rx_data == 8'h78) || (rx_data == 8'h79) || (rx_data == 8'h7A);
  assign busy      = (state != IDLE);

  always_comb begin
    curByte = header;
    case (byteIdx)
      2'd1:    curByte = cap[7:0];
      2'd2:    curByte = cap[15:8];
      2'd3:    curByte = chk;
      default: curByte = header;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      state       <= IDLE;
      settleCnt   <= '0;
      header      <= '0;
      cap         <= '0;
      chk         <= '0;
      byteIdx     <= '0;
      lastIdx     <= '0;
      axisFrame   <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      dimension   <= '0;
      cmd_dropped <= 1'b0;
      frame_count <= '0;
    end else begin
      tx_start    <= 1'b0;
      cmd_dropped <= rx_ready && (state != IDLE);
      case (state)
        IDLE: begin
          if (rx_ready) begin
            byteIdx <= '0;
            if (isAxisCmd) begin
              // 'x','y','z' differ only in the two low bits, which map straight to 0/1/2
              dimension <= {1'b0, rx_data[1:0]};
              header    <= rx_data;
              settleCnt <= '0;
              axisFrame <= 1'b1;
              lastIdx   <= AXIS_LAST;
              state     <= SETTLE;
            end else begin
              header    <= 8'h3F;
              axisFrame <= 1'b0;
              lastIdx   <= 2'd0;
              state     <= LOAD;
            end
          end
        end
        SETTLE: begin
          settleCnt <= settleCnt + 20'd1;
          if (settleCnt == SETTLE_LAST) begin
            cap   <= sample;
            chk   <= header ^ sample[7:0] ^ sample[15:8];
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= curByte;
            state    <= GUARD;
          end
        end
        GUARD: state <= DRAIN;
        DRAIN: begin
          if (!tx_busy) begin
            if (byteIdx != lastIdx) begin
              byteIdx <= byteIdx + 2'd1;
              state   <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (axisFrame) frame_count <= frame_count + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axis_responder.sv
// Directed bench for uart_axis_responder with a small transmitter model (busy one cycle after start).
module tb_uart_axis_responder;

  localparam int SETTLE = 4;
  localparam int TXLEN  = 6;

  logic        CLK_50 = 1'b0;
  logic        iRSTN;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] sample;
  logic [2:0]  dimension;
  logic        busy;
  logic        cmd_dropped;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int startCnt = 0;
  int dropCnt = 0;
  int viol = 0;
  int busyCnt = 0;
  bit forceBusy = 1'b0;
  int expFrames = 0;
  logic [7:0] txLog[$];

  uart_axis_responder #(.SETTLE_CYCLES(SETTLE), .SEND_CHECKSUM(1'b1)) dut (
    .CLK_50(CLK_50), .iRSTN(iRSTN), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .sample(sample),
    .dimension(dimension), .busy(busy), .cmd_dropped(cmd_dropped), .frame_count(frame_count)
  );

  always #10 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) begin
    if (tx_start) busyCnt <= TXLEN;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = (busyCnt != 0) || forceBusy;

  always @(negedge CLK_50) begin
    if (tx_start) begin
      txLog.push_back(tx_data);
      startCnt++;
      if (tx_busy) viol++;
    end
    if (cmd_dropped) dropCnt++;
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge CLK_50);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge CLK_50);
    rx_ready = 1'b0;
  endtask

  task automatic waitIdle(output bit ok);
    int n = 0;
    @(negedge CLK_50);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge CLK_50);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    iRSTN = 1'b0; rx_ready = 1'b0; rx_data = '0; sample = '0;
    repeat (3) @(negedge CLK_50);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (dimension !== 3'd0) begin errors++; $display("FAIL reset_dimension got %0d want 0", dimension); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmd_dropped !== 1'b0) begin errors++; $display("FAIL reset_cmd_dropped got %b want 0", cmd_dropped); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    iRSTN = 1'b1;
    repeat (2) @(negedge CLK_50);
  endtask

  task automatic test_axis_x;
    logic [7:0] exp[4] = '{8'h78, 8'h5A, 8'hA5, 8'h87};
    int cnt;
    bit ok;
    txLog.delete();
    sample = 16'hA55A;
    sendByte(8'h78);
    cnt = 1;
    while (tx_start !== 1'b1 && cnt < 50) begin
      @(negedge CLK_50);
      cnt++;
    end
    checks++; if (cnt != SETTLE + 2) begin errors++; $display("FAIL x_latency got %0d want %0d", cnt, SETTLE + 2); end
    checks++; if (dimension !== 3'd0) begin errors++; $display("FAIL x_dimension got %0d want 0", dimension); end
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL x_idle_timeout got busy %b want 0", busy); end
    expFrames++;
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL x_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== exp[i]) begin errors++; $display("FAIL x_byte%0d got %h want %h", i, txLog[i], exp[i]); end
    end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL x_frame_count got %0d want %0d", frame_count, expFrames); end
  endtask

  task automatic test_axis_yz;
    logic [7:0] expY[4] = '{8'h79, 8'h34, 8'h12, 8'h5F};
    logic [7:0] expZ[4] = '{8'h7A, 8'h34, 8'h12, 8'h5C};
    bit ok;
    sample = 16'h1234;
    txLog.delete();
    sendByte(8'h79);
    @(negedge CLK_50);
    checks++; if (dimension !== 3'd1) begin errors++; $display("FAIL y_dimension got %0d want 1", dimension); end
    waitIdle(ok);
    expFrames++;
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL y_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== expY[i]) begin errors++; $display("FAIL y_byte%0d got %h want %h", i, txLog[i], expY[i]); end
    end
    txLog.delete();
    sendByte(8'h7A);
    @(negedge CLK_50);
    checks++; if (dimension !== 3'd2) begin errors++; $display("FAIL z_dimension got %0d want 2", dimension); end
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL z_idle_timeout got busy %b want 0", busy); end
    expFrames++;
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL z_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== expZ[i]) begin errors++; $display("FAIL z_byte%0d got %h want %h", i, txLog[i], expZ[i]); end
    end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL z_frame_count got %0d want %0d", frame_count, expFrames); end
  endtask

  task automatic test_unknown;
    bit ok;
    txLog.delete();
    sendByte(8'h71);
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL unk_idle_timeout got busy %b want 0", busy); end
    checks++; if (txLog.size() != 1) begin errors++; $display("FAIL unk_nbytes got %0d want 1", txLog.size()); end
    if (txLog.size() > 0) begin
      checks++; if (txLog[0] !== 8'h3F) begin errors++; $display("FAIL unk_byte got %h want 3f", txLog[0]); end
    end
    checks++; if (dimension !== 3'd2) begin errors++; $display("FAIL unk_dimension got %0d want 2", dimension); end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL unk_frame_count got %0d want %0d", frame_count, expFrames); end
  endtask

  task automatic test_drop;
    logic [7:0] exp[4] = '{8'h78, 8'hEF, 8'hBE, 8'h29};
    int dropBase, startBase, n;
    bit ok;
    txLog.delete();
    sample = 16'hBEEF;
    dropBase = dropCnt;
    sendByte(8'h78);
    n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      @(negedge CLK_50);
      n++;
    end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL drop_first_start got %b want 1", tx_start); end
    sample = 16'hFFFF;
    sendByte(8'h78);
    waitIdle(ok);
    expFrames++;
    startBase = startCnt;
    repeat (20) @(negedge CLK_50);
    checks++; if (dropCnt - dropBase != 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", dropCnt - dropBase); end
    checks++; if (startCnt != startBase) begin errors++; $display("FAIL drop_extra_frame got %0d starts want 0", startCnt - startBase); end
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL drop_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== exp[i]) begin errors++; $display("FAIL drop_byte%0d got %h want %h", i, txLog[i], exp[i]); end
    end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL drop_frame_count got %0d want %0d", frame_count, expFrames); end
  endtask

  task automatic test_busy_hold;
    logic [7:0] exp[4] = '{8'h79, 8'hFF, 8'h00, 8'h86};
    int startBase;
    bit ok;
    txLog.delete();
    sample = 16'h00FF;
    forceBusy = 1'b1;
    startBase = startCnt;
    sendByte(8'h79);
    repeat (100) @(negedge CLK_50);
    checks++; if (startCnt != startBase) begin errors++; $display("FAIL hold_start_while_busy got %0d starts want 0", startCnt - startBase); end
    forceBusy = 1'b0;
    @(negedge CLK_50);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL hold_release_start got %b want 1", tx_start); end
    @(negedge CLK_50);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL hold_start_width got %b want 0", tx_start); end
    waitIdle(ok);
    expFrames++;
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL hold_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== exp[i]) begin errors++; $display("FAIL hold_byte%0d got %h want %h", i, txLog[i], exp[i]); end
    end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL hold_frame_count got %0d want %0d", frame_count, expFrames); end
    checks++; if (viol != 0) begin errors++; $display("FAIL start_during_busy got %0d want 0", viol); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp[4] = '{8'h7A, 8'h55, 8'h55, 8'h7A};
    int startBase, n;
    bit ok;
    sample = 16'h5555;
    startBase = startCnt;
    sendByte(8'h78);
    n = 0;
    while (startCnt < startBase + 2 && n < 200) begin
      @(negedge CLK_50);
      n++;
    end
    checks++; if (startCnt != startBase + 2) begin errors++; $display("FAIL mid_second_byte got %0d starts want 2", startCnt - startBase); end
    @(negedge CLK_50);
    #1 iRSTN = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (dimension !== 3'd0) begin errors++; $display("FAIL mid_dimension got %0d want 0", dimension); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL mid_frame_count got %0d want 0", frame_count); end
    @(negedge CLK_50);
    iRSTN = 1'b1;
    expFrames = 0;
    txLog.delete();
    sendByte(8'h7A);
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_idle_timeout got busy %b want 0", busy); end
    expFrames++;
    checks++; if (txLog.size() != 4) begin errors++; $display("FAIL mid_nbytes got %0d want 4", txLog.size()); end
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checks++; if (txLog[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d got %h want %h", i, txLog[i], exp[i]); end
    end
    checks++; if (frame_count !== 8'(expFrames)) begin errors++; $display("FAIL mid_frame_count_after got %0d want %0d", frame_count, expFrames); end
    checks++; if (dimension !== 3'd2) begin errors++; $display("FAIL mid_dimension_after got %0d want 2", dimension); end
  endtask

  initial begin
    test_reset();
    test_axis_x();
    test_axis_yz();
    test_unknown();
    test_drop();
    test_busy_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
